// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU core.
package alu_pkg;

   localparam logic [7:0] OP_NOP = 8'd0;
   localparam logic [7:0] OP_ADD = 8'd1;
   localparam logic [7:0] OP_SUB = 8'd2;
   localparam logic [7:0] OP_MUL = 8'd3;
   localparam logic [7:0] OP_AND = 8'd4;
   localparam logic [7:0] OP_OR  = 8'd5;
   localparam logic [7:0] OP_NOT = 8'd6;
   localparam logic [7:0] OP_XOR = 8'd7;
   localparam logic [7:0] OP_INC = 8'd8;
   localparam logic [7:0] OP_DEC = 8'd9;
   localparam logic [7:0] OP_ROR = 8'd10;
   localparam logic [7:0] OP_ROL = 8'd11;
   localparam logic [7:0] OP_RSH = 8'd12;
   localparam logic [7:0] OP_LSH = 8'd13;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles after start, with a one-cycle done pulse and a held product.
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   logic [2*WIDTH-1:0] acc_r;
   logic [2*WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [CW-1:0]      count_r;
   logic               busy_r;
   logic               done_r;
   logic [2*WIDTH-1:0] product_r;
   logic [2*WIDTH-1:0] next_acc_s;

   // Partial-product accumulate for the current multiplier LSB.
   always_comb begin
      next_acc_s = acc_r;
      if (mplier_r[0]) begin
         next_acc_s = acc_r + mcand_r;
      end else begin
         next_acc_s = acc_r;
      end
   end

   // Operand load on start, then one shift-add step per cycle until the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r     <= {(2*WIDTH){1'b0}};
         mcand_r   <= {(2*WIDTH){1'b0}};
         mplier_r  <= {WIDTH{1'b0}};
         count_r   <= {CW{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         product_r <= {(2*WIDTH){1'b0}};
      end else begin
         done_r <= 1'b0;
         if (start && !busy_r) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b1;
         end else if (busy_r) begin
            acc_r    <= next_acc_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            count_r  <= count_r + ONE_CNT;
            if (count_r == LAST_CNT) begin
               busy_r    <= 1'b0;
               done_r    <= 1'b1;
               product_r <= next_acc_s;
            end else begin
               busy_r    <= 1'b1;
            end
         end else begin
            busy_r <= 1'b0;
         end
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign product = product_r;

endmodule

// File: rtl/seq_alu_core.sv
// Registered ALU core with valid/ready handshakes on both sides. Single-cycle
// opcodes load the output register on the accept edge; MUL is handed to the
// iterative multiplier and its product loads the output register on completion.
module seq_alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           instruction,
   input  logic [WIDTH-1:0]     op1,
   input  logic [WIDTH-1:0]     op2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out,
   output logic                 carry_flag,
   output logic                 parity_flag,
   output logic                 zero_flag,
   output logic                 eq_flag,
   output logic                 gt_flag,
   output logic                 illegal_op
);

   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

   state_t             state_r;
   logic [2*WIDTH-1:0] out_r;
   logic               out_valid_r;
   logic               carry_r;
   logic               parity_r;
   logic               zero_r;
   logic               eq_r;
   logic               gt_r;
   logic               illegal_r;

   logic               accept_s;
   logic               mul_start_s;
   logic               mul_busy_s;
   logic               mul_done_s;
   logic [2*WIDTH-1:0] mul_product_s;
   logic               load_s;
   logic [WIDTH:0]     sum_s;
   logic [WIDTH:0]     diff_s;
   logic [2*WIDTH-1:0] alu_res_s;
   logic               alu_carry_s;
   logic               alu_illegal_s;
   logic [2*WIDTH-1:0] next_out_s;
   logic               next_carry_s;

   function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] v);
      return {{WIDTH{1'b0}}, v};
   endfunction

   function automatic logic calc_parity(input logic [2*WIDTH-1:0] v);
      return ^v;
   endfunction

   assign in_ready    = (state_r == ST_IDLE) & ~mul_busy_s & (~out_valid_r | out_ready);
   assign accept_s    = in_valid & in_ready;
   assign mul_start_s = accept_s & (instruction == OP_MUL);
   assign load_s      = (accept_s & (instruction != OP_MUL))
                      | ((state_r == ST_MUL_BUSY) & mul_done_s);

   seq_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start_s),
      .a       (op1),
      .b       (op2),
      .busy    (mul_busy_s),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

   // Single-cycle opcode decode; carry defaults to its held value for logic ops.
   always_comb begin
      sum_s         = {1'b0, op1} + {1'b0, op2};
      diff_s        = {1'b0, op1} - {1'b0, op2};
      alu_res_s     = {(2*WIDTH){1'b0}};
      alu_carry_s   = carry_r;
      alu_illegal_s = 1'b0;
      case (instruction)
         OP_NOP: begin alu_res_s = out_r;                                  alu_carry_s = carry_r;        end
         OP_ADD: begin alu_res_s = zext(sum_s[WIDTH-1:0]);                 alu_carry_s = sum_s[WIDTH];   end
         OP_SUB: begin alu_res_s = zext(diff_s[WIDTH-1:0]);                alu_carry_s = diff_s[WIDTH];  end
         OP_MUL: begin alu_res_s = {(2*WIDTH){1'b0}};                      alu_carry_s = 1'b0;           end
         OP_AND: begin alu_res_s = zext(op1 & op2);                        alu_carry_s = carry_r;        end
         OP_OR:  begin alu_res_s = zext(op1 | op2);                        alu_carry_s = carry_r;        end
         OP_NOT: begin alu_res_s = zext(~op1);                             alu_carry_s = carry_r;        end
         OP_XOR: begin alu_res_s = zext(op1 ^ op2);                        alu_carry_s = carry_r;        end
         OP_INC: begin alu_res_s = zext(op1 + ONE_W);                      alu_carry_s = &op1;           end
         OP_DEC: begin alu_res_s = zext(op1 - ONE_W);                      alu_carry_s = ~|op1;          end
         OP_ROR: begin alu_res_s = zext({op1[0], op1[WIDTH-1:1]});         alu_carry_s = op1[0];         end
         OP_ROL: begin alu_res_s = zext({op1[WIDTH-2:0], op1[WIDTH-1]});   alu_carry_s = op1[WIDTH-1];   end
         OP_RSH: begin alu_res_s = zext({1'b0, op1[WIDTH-1:1]});           alu_carry_s = op1[0];         end
         OP_LSH: begin alu_res_s = zext({op1[WIDTH-2:0], 1'b0});           alu_carry_s = op1[WIDTH-1];   end
         default: begin
            alu_res_s     = {(2*WIDTH){1'b0}};
            alu_carry_s   = carry_r;
            alu_illegal_s = 1'b1;
         end
      endcase
   end

   // Select what the output register loads: the multiplier product or the ALU result.
   always_comb begin
      next_out_s   = alu_res_s;
      next_carry_s = alu_carry_s;
      if (state_r == ST_MUL_BUSY) begin
         next_out_s   = mul_product_s;
         next_carry_s = 1'b0;
      end else begin
         next_out_s   = alu_res_s;
         next_carry_s = alu_carry_s;
      end
   end

   // FSM plus output register stage; a held result is never overwritten until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         out_r       <= {(2*WIDTH){1'b0}};
         out_valid_r <= 1'b0;
         carry_r     <= 1'b0;
         parity_r    <= 1'b0;
         zero_r      <= 1'b0;
         eq_r        <= 1'b0;
         gt_r        <= 1'b0;
         illegal_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (mul_start_s) begin
                  state_r <= ST_MUL_BUSY;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_MUL_BUSY: begin
               if (mul_done_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_MUL_BUSY;
               end
            end
            default: state_r <= ST_IDLE;
         endcase

         if (accept_s) begin
            eq_r      <= (op1 == op2);
            gt_r      <= (op1 > op2);
            illegal_r <= alu_illegal_s;
         end else begin
            eq_r      <= eq_r;
            gt_r      <= gt_r;
            illegal_r <= illegal_r;
         end

         if (load_s) begin
            out_r       <= next_out_s;
            carry_r     <= next_carry_s;
            parity_r    <= calc_parity(next_out_s);
            zero_r      <= (next_out_s == {(2*WIDTH){1'b0}});
            out_valid_r <= 1'b1;
         end else if (out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign out         = out_r;
   assign out_valid   = out_valid_r;
   assign carry_flag  = carry_r;
   assign parity_flag = parity_r;
   assign zero_flag   = zero_r;
   assign eq_flag     = eq_r;
   assign gt_flag     = gt_r;
   assign illegal_op  = illegal_r;

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core: an 8-bit instance for all opcodes and
// handshake cases, and a 16-bit instance for the wide multiply.
module tb_seq_alu_core;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  instruction, op1, op2;
   logic [15:0] out8;
   logic        carry, parity, zero, eq, gt, illegal;

   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [7:0]  instruction16;
   logic [15:0] a16, b16;
   logic [31:0] out16;
   logic        carry16, parity16, zero16, eq16, gt16, illegal16;

   int tests;
   int fails;
   int cnt;

   seq_alu_core #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .op1(op1), .op2(op2),
      .out_valid(out_valid), .out_ready(out_ready), .out(out8),
      .carry_flag(carry), .parity_flag(parity), .zero_flag(zero),
      .eq_flag(eq), .gt_flag(gt), .illegal_op(illegal)
   );

   seq_alu_core #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .instruction(instruction16), .op1(a16), .op2(b16),
      .out_valid(out_valid16), .out_ready(out_ready16), .out(out16),
      .carry_flag(carry16), .parity_flag(parity16), .zero_flag(zero16),
      .eq_flag(eq16), .gt_flag(gt16), .illegal_op(illegal16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One-cycle request on the 8-bit core; returns 1 time unit after the edge.
   task automatic issue(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b);
      instruction = ins;
      op1         = a;
      op2         = b;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; instruction = 8'd0; op1 = 8'd0; op2 = 8'd0;
      in_valid16 = 1'b0; out_ready16 = 1'b1; instruction16 = 8'd0; a16 = 16'd0; b16 = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out", {16'd0, out8}, 32'd0);
      chk("rst_carry", {31'd0, carry}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // 1. ADD with carry out
      issue(OP_ADD, 8'd200, 8'd100);
      chk("add_valid", {31'd0, out_valid}, 32'd1);
      chk("add_out", {16'd0, out8}, 32'd44);
      chk("add_carry", {31'd0, carry}, 32'd1);
      chk("add_zero", {31'd0, zero}, 32'd0);
      chk("add_parity", {31'd0, parity}, 32'd1);

      // 2. SUB with borrow, then XOR leaves carry alone
      issue(OP_SUB, 8'd5, 8'd7);
      chk("sub_out", {16'd0, out8}, 32'd254);
      chk("sub_carry", {31'd0, carry}, 32'd1);
      chk("sub_gt", {31'd0, gt}, 32'd0);
      chk("sub_eq", {31'd0, eq}, 32'd0);
      issue(OP_XOR, 8'hF0, 8'h3C);
      chk("xor_out", {16'd0, out8}, 32'h00CC);
      chk("xor_carry", {31'd0, carry}, 32'd1);
      chk("xor_parity", {31'd0, parity}, 32'd0);

      // 3. MUL 255*255, latency WIDTH+1
      issue(OP_MUL, 8'd255, 8'd255);
      cnt = 0;
      while (!out_valid && cnt < 30) begin
         @(posedge clk);
         #1;
         cnt++;
         if (cnt <= 8) chk("mul_in_ready_low", {31'd0, in_ready}, 32'd0);
      end
      chk("mul_latency", cnt, 32'd9);
      chk("mul_out", {16'd0, out8}, 32'd65025);
      chk("mul_carry", {31'd0, carry}, 32'd0);
      chk("mul_parity", {31'd0, parity}, 32'd0);

      // 3b. 16-bit MUL
      instruction16 = OP_MUL; a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
      @(posedge clk);
      #1;
      in_valid16 = 1'b0;
      cnt = 0;
      while (!out_valid16 && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("mul16_latency", cnt, 32'd17);
      chk("mul16_out", out16, 32'hFFFE0001);

      // 4. Backpressure holds result and blocks new requests
      out_ready = 1'b0;
      issue(OP_ADD, 8'd1, 8'd1);
      chk("bp_out", {16'd0, out8}, 32'd2);
      instruction = OP_ADD; op1 = 8'd5; op2 = 8'd6; in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_hold_out", {16'd0, out8}, 32'd2);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_next_out", {16'd0, out8}, 32'd11);
      chk("bp_next_valid", {31'd0, out_valid}, 32'd1);

      // 5. Reset in the middle of a MUL
      issue(OP_MUL, 8'd17, 8'd15);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_out", {16'd0, out8}, 32'd0);
      chk("mrst_gt", {31'd0, gt}, 32'd0);
      chk("mrst_carry", {31'd0, carry}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("mrst_no_result", {31'd0, out_valid}, 32'd0);
      issue(OP_ADD, 8'd3, 8'd4);
      chk("mrst_add_out", {16'd0, out8}, 32'd7);

      // 6. Illegal opcode and NOP
      issue(OP_DEC, 8'd0, 8'd0);
      chk("dec_out", {16'd0, out8}, 32'd255);
      chk("dec_carry", {31'd0, carry}, 32'd1);
      issue(8'h20, 8'd9, 8'd1);
      chk("ill_out", {16'd0, out8}, 32'd0);
      chk("ill_flag", {31'd0, illegal}, 32'd1);
      chk("ill_zero", {31'd0, zero}, 32'd1);
      chk("ill_carry", {31'd0, carry}, 32'd1);
      issue(OP_NOP, 8'd0, 8'd0);
      chk("nop_valid", {31'd0, out_valid}, 32'd1);
      chk("nop_out", {16'd0, out8}, 32'd0);
      chk("nop_carry", {31'd0, carry}, 32'd1);
      chk("nop_illegal", {31'd0, illegal}, 32'd0);
      issue(OP_ROL, 8'h81, 8'd0);
      chk("rol_out", {16'd0, out8}, 32'h03);
      issue(OP_NOP, 8'd0, 8'd0);
      chk("nop2_out", {16'd0, out8}, 32'h03);
      chk("nop2_carry", {31'd0, carry}, 32'd1);

      // Remaining opcodes
      issue(OP_ADD, 8'd9, 8'd9);
      chk("eq_out", {16'd0, out8}, 32'd18);
      chk("eq_flag", {31'd0, eq}, 32'd1);
      chk("eq_carry", {31'd0, carry}, 32'd0);
      issue(OP_NOT, 8'h0F, 8'd0);
      chk("not_out", {16'd0, out8}, 32'hF0);
      issue(OP_AND, 8'hF0, 8'h3C);
      chk("and_out", {16'd0, out8}, 32'h30);
      issue(OP_OR, 8'hF0, 8'h3C);
      chk("or_out", {16'd0, out8}, 32'hFC);
      issue(OP_RSH, 8'h02, 8'd0);
      chk("rsh_out", {16'd0, out8}, 32'h01);
      chk("rsh_carry", {31'd0, carry}, 32'd0);
      issue(OP_LSH, 8'h81, 8'd0);
      chk("lsh_out", {16'd0, out8}, 32'h02);
      chk("lsh_carry", {31'd0, carry}, 32'd1);
      issue(OP_ROR, 8'h02, 8'd0);
      chk("ror_out", {16'd0, out8}, 32'h01);
      chk("ror_carry", {31'd0, carry}, 32'd0);
      issue(OP_INC, 8'hFF, 8'd0);
      chk("inc_out", {16'd0, out8}, 32'd0);
      chk("inc_carry", {31'd0, carry}, 32'd1);
      chk("inc_zero", {31'd0, zero}, 32'd1);
      issue(OP_SUB, 8'd7, 8'd5);
      chk("sub2_out", {16'd0, out8}, 32'd2);
      chk("sub2_carry", {31'd0, carry}, 32'd0);
      chk("sub2_gt", {31'd0, gt}, 32'd1);

      @(posedge clk);
      #1;
      chk("idle_valid_clear", {31'd0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
